grant_arbiter_8: RTL and testbench
==================================

# grant_arbiter_8

Round-robin arbiter sharing one resource among 8 requesters. It selects one requester, holds the grant while that request stays high, and forcibly releases it after `MAX_HOLD` cycles. The grant is produced as a 3-bit index, and the existing shift-based 3-to-8 decoder expands it into a one-hot grant vector. The block sits between the requesters and the shared datapath.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one grant may be held. Legal range is 1..255.
- `clk`  in  1: rising-edge clock, the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  8: request vector. Bit i belongs to requester i. Level-sensitive.
- `gnt`  out  8: one-hot grant, all-zero when no grant is active.
- `gnt_idx`  out  3: index of the current or last granter.
- `gnt_valid`  out  1: a grant is active.
- `timeout`  out  1: one-cycle pulse on the cycle a grant is forcibly ended.

## Operation
- Two states: IDLE and GRANT.
- Round-robin pointer `ptr` (3 bits) holds the index most recently granted.
- Priority order starts at `ptr+1` and wraps modulo 8, so index 7 is followed by 0.
- In IDLE:
  - If `req` is non-zero, pick the first set bit in priority order.
  - Load `gnt_idx` with it, set `ptr` to it, clear `hold_cnt`, and go to GRANT.
  - If `req` is zero, stay in IDLE.
- In GRANT, `hold_cnt` increments every cycle. Exits are checked in this order:
  1. If `req[gnt_idx]` is 0, go to IDLE (normal release).
  2. Else if `hold_cnt == MAX_HOLD-1`, go to IDLE and pulse `timeout` for one cycle (forced release).
  3. Else stay in GRANT.
- Output derivation:
  - `gnt` is the decoder output of `gnt_idx`, ANDed with `gnt_valid`.
  - `gnt_valid` is 1 exactly while the state is GRANT.
- Fairness:
  - After any release, the released index has the lowest priority at the next arbitration.
  - If all 8 requesters are held high continuously, grants are served 0,1,…,7,0,…
- Requests that rise or fall in bits other than `gnt_idx` during GRANT are ignored until the next IDLE.
- Reset values: state IDLE, `ptr` = 7 (so requester 0 wins first), `gnt_idx` = 0, `gnt_valid` = 0, `gnt` = 0, `timeout` = 0, `hold_cnt` = 0.
- Reset during GRANT clears all outputs asynchronously. The next arbitration after reset restarts from `ptr` = 7.
- `hold_cnt` width is 8 bits. It never exceeds `MAX_HOLD-1`.

## Timing
- Grant latency: `req` is sampled non-zero in IDLE at edge k, and `gnt` and `gnt_valid` are high from edge k+1.
- Release latency: `req[gnt_idx]` is sampled low at edge k. `gnt` is low from edge k+1, which is an IDLE cycle that arbitrates. The next grant is visible from edge k+2.
- Minimum dead time between consecutive grants is one cycle, with `gnt` = 0.
- Forced release: with the request held high, the grant is high for exactly `MAX_HOLD` cycles.
  - `timeout` is high during the first IDLE cycle after the grant, coincident with `gnt` = 0.
- With `MAX_HOLD` = 1, every grant lasts one cycle and always ends with `timeout`, unless the request has already dropped.
- `gnt_idx` holds its value through IDLE. It changes only at the edge that enters GRANT.

## Structure
- Shared package `decoder_pkg`:
  - `N = 3` and `NUM_REQ = 2**N`.
  - State enum `arb_state_t {IDLE, GRANT}`.
  - `HOLD_W = 8`.
- One sub-module: the existing `decoder_3_8`, instantiated once to convert `gnt_idx` into the one-hot vector.
- Round-robin selection is a rotate-priority-encode-rotate-back function local to the block. No second sub-module.

## Test plan
- Single requester: after reset, `req = 8'b0000_0100` held for 5 cycles.
  - Expect `gnt = 8'b0000_0100` one cycle later, held while `req` is held.
  - `gnt` goes to 0 one cycle after `req` drops. `gnt_idx` = 2.
- Simultaneous requests: after reset, `req = 8'b1000_0001`, and each granted requester drops its request after 2 grant cycles.
  - Expect grant order 0 then 7, with one dead cycle between.
  - With both requests then re-raised, expect 0 next (pointer is at 7).
- Full rotation: `req = 8'hFF`, and each requester drops its request for one cycle after 1 grant cycle.
  - Expect `gnt_idx` sequence 0,1,2,…,7,0.
  - Every grant is separated by exactly one zero cycle.
- Timeout with `MAX_HOLD` = 4: `req[3]` and `req[5]` held high.
  - `gnt[3]` is high for exactly 4 cycles, then `timeout` = 1 for one cycle with `gnt` = 0.
  - `gnt[5]` follows for 4 cycles, then `gnt[3]` again.
- Reset mid-grant: assert `rst_n` = 0 asynchronously two cycles into a grant of requester 6.
  - `gnt`, `gnt_valid` and `timeout` go to 0 immediately.
  - After release with `req = 8'b0100_0001`, requester 0 is granted first.
- Ignored requests: during a grant of requester 1, pulse `req[0]` high for 1 cycle only.
  - No change to `gnt`. No grant to requester 0 after the release.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared definitions for the 8-way grant arbiter and its index decoder.
package decoder_pkg;
  localparam int N       = 3;
  localparam int NUM_REQ = 2**N;
  localparam int HOLD_W  = 8;

  typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/decoder_3_8.sv
// Shift-based 3-to-8 decoder: turns a grant index into a one-hot vector.
module decoder_3_8
  import decoder_pkg::*;
(
  input  logic [N-1:0]       i_a,
  output logic [NUM_REQ-1:0] o_y
);
  assign o_y = NUM_REQ'(1) << i_a;
endmodule

// File: rtl/grant_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a bounded hold time per grant.
module grant_arbiter_8
  import decoder_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [N-1:0]       gnt_idx,
  output logic               gnt_valid,
  output logic               timeout,
  output arb_state_t         dbg_state
);
  // Protocol: req[i] is a level held by requester i for as long as it wants
  // the resource; gnt[i] high means requester i owns it this cycle. Dropping
  // req[i] releases the grant; the owner loses it anyway after MAX_HOLD cycles.

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [N-1:0]        r_ptr, w_ptr_nxt;
  logic [N-1:0]        r_gnt_idx, w_gnt_idx_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt, w_hold_cnt_nxt;
  logic                r_timeout, w_timeout_nxt;
  logic [N-1:0]        w_rr_idx;
  logic [NUM_REQ-1:0]  w_dec;

  // Rotate so ptr+1 sits at bit 0, take the lowest set bit, rotate back.
  function automatic logic [N-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                           input logic [N-1:0]       p);
    logic [N-1:0]       start;
    logic [NUM_REQ-1:0] rot;
    logic [N-1:0]       enc;
    logic               found;
    start = p + N'(1);
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = r[start + N'(i)];
    end
    enc   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        enc   = N'(i);
        found = 1'b1;
      end
    end
    return enc + start;
  endfunction

  assign w_rr_idx = rr_pick(req, r_ptr);

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_gnt_idx_nxt  = r_gnt_idx;
    w_hold_cnt_nxt = r_hold_cnt;
    w_timeout_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_state_nxt    = GRANT;
          w_gnt_idx_nxt  = w_rr_idx;
          w_ptr_nxt      = w_rr_idx;
          w_hold_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (!req[r_gnt_idx]) begin
          w_state_nxt = IDLE;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt   = IDLE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= N'(NUM_REQ - 1);
      r_gnt_idx  <= '0;
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_gnt_idx  <= w_gnt_idx_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  decoder_3_8 u_dec (
    .i_a (r_gnt_idx),
    .o_y (w_dec)
  );

  assign gnt_valid = (r_state == GRANT);
  assign gnt       = w_dec & {NUM_REQ{gnt_valid}};
  assign gnt_idx   = r_gnt_idx;
  assign timeout   = r_timeout;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_grant_arbiter_8.sv
// Directed bench for grant_arbiter_8: default hold limit plus a MAX_HOLD=4 copy.
module tb_grant_arbiter_8;
  import decoder_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] req, req4;
  logic [7:0] gnt, gnt4;
  logic [2:0] gnt_idx, gnt_idx4;
  logic       gnt_valid, gnt_valid4;
  logic       timeout, timeout4;
  arb_state_t dbg_state, dbg_state4;

  int n_vec;
  int n_miss;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  grant_arbiter_8 #(.MAX_HOLD(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .gnt_idx(gnt_idx),
    .gnt_valid(gnt_valid), .timeout(timeout), .dbg_state(dbg_state)
  );

  grant_arbiter_8 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .gnt(gnt4), .gnt_idx(gnt_idx4),
    .gnt_valid(gnt_valid4), .timeout(timeout4), .dbg_state(dbg_state4)
  );

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    req4  = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic [7:0] e_gnt,
                          input logic [2:0] e_idx, input logic e_valid,
                          input logic e_to);
    chk({tag, ".gnt"},     gnt,                  e_gnt);
    chk({tag, ".idx"},     {5'd0, gnt_idx},      {5'd0, e_idx});
    chk({tag, ".valid"},   {7'd0, gnt_valid},    {7'd0, e_valid});
    chk({tag, ".timeout"}, {7'd0, timeout},      {7'd0, e_to});
  endtask

  task automatic chk4(input string tag, input logic [7:0] e_gnt, input logic e_to);
    chk({tag, ".gnt4"},     gnt4,               e_gnt);
    chk({tag, ".timeout4"}, {7'd0, timeout4},   {7'd0, e_to});
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    req    = 8'h00;
    req4   = 8'h00;
    #2;
    chk_main("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    do_reset();
    tick();
    chk_main("reset_idle", 8'h00, 3'd0, 1'b0, 1'b0);
    chk4("reset_idle", 8'h00, 1'b0);

    // single requester 2 held for 5 cycles
    req = 8'b0000_0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_main("single_hold", 8'h04, 3'd2, 1'b1, 1'b0);
    end
    req = 8'h00;
    tick();
    chk_main("single_release", 8'h00, 3'd2, 1'b0, 1'b0);
    tick();
    chk_main("single_idle", 8'h00, 3'd2, 1'b0, 1'b0);

    // simultaneous 0 and 7, each drops after 2 grant cycles
    do_reset();
    req = 8'b1000_0001;
    tick();
    chk_main("simul_g0a", 8'h01, 3'd0, 1'b1, 1'b0);
    tick();
    chk_main("simul_g0b", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'b1000_0000;
    tick();
    chk_main("simul_dead", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    chk_main("simul_g7a", 8'h80, 3'd7, 1'b1, 1'b0);
    tick();
    chk_main("simul_g7b", 8'h80, 3'd7, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    chk_main("simul_dead2", 8'h00, 3'd7, 1'b0, 1'b0);
    req = 8'b1000_0001;
    tick();
    chk_main("simul_rearm", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    tick();

    // full rotation with all requesters high
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      logic [2:0] e_idx;
      logic [7:0] e_gnt;
      e_idx = 3'(i % 8);
      e_gnt = 8'h01 << e_idx;
      tick();
      chk_main("rot_grant", e_gnt, e_idx, 1'b1, 1'b0);
      req = 8'hFF & ~e_gnt;
      tick();
      chk_main("rot_dead", 8'h00, e_idx, 1'b0, 1'b0);
      req = 8'hFF;
    end
    req = 8'h00;
    tick();

    // timeout on the MAX_HOLD=4 instance with requesters 3 and 5
    do_reset();
    req4 = 8'b0010_1000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk4("to_g3", 8'h08, 1'b0);
    end
    tick();
    chk4("to_pulse3", 8'h00, 1'b1);
    chk({"to_pulse3.valid4"}, {7'd0, gnt_valid4}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk4("to_g5", 8'h20, 1'b0);
      chk("to_g5.idx4", {5'd0, gnt_idx4}, 8'd5);
    end
    tick();
    chk4("to_pulse5", 8'h00, 1'b1);
    tick();
    chk4("to_g3_again", 8'h08, 1'b0);
    req4 = 8'h00;
    tick();

    // asynchronous reset two cycles into a grant of requester 6
    do_reset();
    req = 8'b0100_0000;
    tick();
    chk_main("rst_g6a", 8'h40, 3'd6, 1'b1, 1'b0);
    tick();
    chk_main("rst_g6b", 8'h40, 3'd6, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_main("rst_mid", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    req   = 8'b0100_0001;
    rst_n = 1'b1;
    tick();
    chk_main("rst_after", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    tick();

    // requester 0 pulses during a grant of requester 1 and is ignored
    do_reset();
    req = 8'b0000_0010;
    tick();
    chk_main("ign_g1a", 8'h02, 3'd1, 1'b1, 1'b0);
    req = 8'b0000_0011;
    tick();
    chk_main("ign_g1b", 8'h02, 3'd1, 1'b1, 1'b0);
    req = 8'b0000_0010;
    tick();
    chk_main("ign_g1c", 8'h02, 3'd1, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    chk_main("ign_rel", 8'h00, 3'd1, 1'b0, 1'b0);
    tick();
    chk_main("ign_nog0", 8'h00, 3'd1, 1'b0, 1'b0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
